regfile_sb: RTL and testbench

Parametrised register file with a per-register busy scoreboard for the pipelined DLX datapath. It provides two asynchronous read ports, one writeback port and a dedicated link-register write port. Optional write-to-read bypass and a busy bit per register let decode detect RAW hazards. It sits between decode (reads, issue) and writeback; jump-and-link logic drives the link port.

---
 rtl/regfile_sb_if.sv | 34 +++
 rtl/regfile_sb.sv | 136 +++++++++++++
 tb/tb_regfile_sb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register file bus: writeback, link write, issue/flush and two read ports.
// The master side (decode/writeback) drives addresses, enables and data.
// The slave side (regfile_sb) returns read data and busy flags combinationally.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              link_en;
  logic [DATA_W-1:0] link_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_rd;
  logic              flush;
  logic [ADDR_W-1:0] ra_sel;
  logic [ADDR_W-1:0] rb_sel;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              ra_busy;
  logic              rb_busy;

  modport master (
    output we, waddr, wdata, link_en, link_data,
    output issue_en, issue_rd, flush, ra_sel, rb_sel,
    input  ra_data, rb_data, ra_busy, rb_busy
  );

  modport slave (
    input  we, waddr, wdata, link_en, link_data,
    input  issue_en, issue_rd, flush, ra_sel, rb_sel,
    output ra_data, rb_data, ra_busy, rb_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard; r0 hardwired to zero.
// Writes commit at the rising edge; reads are combinational, optionally bypassing same-cycle writes.
// No backpressure: every enable is a single-cycle pulse consumed at the edge.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              busy;
  } rd_t;

  // Local copies of the bus inputs
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              link_en;
  logic [DATA_W-1:0] link_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_rd;
  logic              flush;

  assign we        = bus.we;
  assign waddr     = bus.waddr;
  assign wdata     = bus.wdata;
  assign link_en   = bus.link_en;
  assign link_data = bus.link_data;
  assign issue_en  = bus.issue_en;
  assign issue_rd  = bus.issue_rd;
  assign flush     = bus.flush;

  // Storage and scoreboard
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  // Per-register decode of the three update sources; r0 never matches
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] lk_hit;
  logic [NREG-1:0] is_hit;

  // Decode which registers the writeback, link and issue ports target this cycle
  always_comb begin
    wr_hit = '0;
    lk_hit = '0;
    is_hit = '0;
    for (int i = 1; i < NREG; i++) begin
      wr_hit[i] = we && (waddr == ADDR_W'(i));
      lk_hit[i] = link_en && (i == LINK_REG);
      is_hit[i] = issue_en && (issue_rd == ADDR_W'(i));
    end
  end

  // Register storage: link write wins over a writeback to the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (lk_hit[i]) begin
          regs[i] <= link_data;
        end else if (wr_hit[i]) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  // Busy next state: flush beats issue, issue beats a clear by a completing write
  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < NREG; i++) begin
      if (flush) begin
        busy_nxt[i] = 1'b0;
      end else if (is_hit[i]) begin
        busy_nxt[i] = 1'b1;
      end else if (wr_hit[i] || lk_hit[i]) begin
        busy_nxt[i] = 1'b0;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read ports
  logic [ADDR_W-1:0] sel [2];
  rd_t               rd  [2];

  assign sel[0] = bus.ra_sel;
  assign sel[1] = bus.rb_sel;

  // Each read port: stored value, optionally overridden by a same-cycle write;
  // forced to zero for r0 and while reset is held
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p].data = regs[sel[p]];
      rd[p].busy = busy[sel[p]];
      if (BYPASS) begin
        if (link_en && (sel[p] == LINK_ADDR)) begin
          rd[p].data = link_data;
          rd[p].busy = 1'b0;
        end else if (we && (waddr == sel[p])) begin
          rd[p].data = wdata;
          rd[p].busy = 1'b0;
        end
      end
      if (rst || (sel[p] == '0)) begin
        rd[p] = '0;
      end
    end
  end

  assign bus.ra_data = rd[0].data;
  assign bus.ra_busy = rd[0].busy;
  assign bus.rb_data = rd[1].data;
  assign bus.rb_busy = rd[1].busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (bypass on/off) share stimulus and are checked
// against a behavioural model every cycle, plus hand-computed literal checks.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        link_en = 1'b0;
  logic [31:0] link_data = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        flush = 1'b0;
  logic [4:0]  ra_sel = '0;
  logic [4:0]  rb_sel = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

  assign bus1.we = we;        assign bus0.we = we;
  assign bus1.waddr = waddr;  assign bus0.waddr = waddr;
  assign bus1.wdata = wdata;  assign bus0.wdata = wdata;
  assign bus1.link_en = link_en;     assign bus0.link_en = link_en;
  assign bus1.link_data = link_data; assign bus0.link_data = link_data;
  assign bus1.issue_en = issue_en;   assign bus0.issue_en = issue_en;
  assign bus1.issue_rd = issue_rd;   assign bus0.issue_rd = issue_rd;
  assign bus1.flush = flush;  assign bus0.flush = flush;
  assign bus1.ra_sel = ra_sel; assign bus0.ra_sel = ra_sel;
  assign bus1.rb_sel = rb_sel; assign bus0.rb_sel = rb_sel;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));

  // Behavioural model: architectural register values and busy flags
  logic [31:0] mdl   [32];
  logic        mbusy [32];

  // Apply the update rules in ascending priority; later statements override earlier ones
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mdl[i] = 32'h0;
        mbusy[i] = 1'b0;
      end
    end else begin
      if (we) begin
        mdl[waddr] = wdata;
        mbusy[waddr] = 1'b0;
      end
      if (link_en) begin
        mdl[31] = link_data;
        mbusy[31] = 1'b0;
      end
      if (issue_en) mbusy[issue_rd] = 1'b1;
      if (flush) for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
      mdl[0] = 32'h0;
      mbusy[0] = 1'b0;
    end
  end

  // Expected {busy, data} seen on a read port for the given select
  function automatic logic [32:0] exp_rd(input logic [4:0] s, input bit byp);
    if (rst || s == 5'd0) return 33'h0;
    if (byp && link_en && s == 5'd31) return {1'b0, link_data};
    if (byp && we && waddr == s) return {1'b0, wdata};
    return {mbusy[s], mdl[s]};
  endfunction

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle, mid-way between the input change and the next rising edge
  always @(negedge clk) begin
    #2;
    chk("b1_ra", {bus1.ra_busy, bus1.ra_data}, exp_rd(ra_sel, 1'b1));
    chk("b1_rb", {bus1.rb_busy, bus1.rb_data}, exp_rd(rb_sel, 1'b1));
    chk("b0_ra", {bus0.ra_busy, bus0.ra_data}, exp_rd(ra_sel, 1'b0));
    chk("b0_rb", {bus0.rb_busy, bus0.rb_data}, exp_rd(rb_sel, 1'b0));
  end

  task automatic idle();
    we = 1'b0; link_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk); #3;
    chk("rst_ra", {bus1.ra_busy, bus1.ra_data}, 33'h0);
    @(negedge clk); rst = 1'b0;

    // Write r5, then async reset in mid-cycle with a pending write to r6
    @(negedge clk); we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
    @(negedge clk); idle(); ra_sel = 5'd5;
    #1 we = 1'b1; waddr = 5'd6; wdata = 32'hBEEF;
    #2 chk("r5_before_rst", {bus0.ra_busy, bus0.ra_data}, {1'b0, 32'h1234});
    rst = 1'b1;
    #1 chk("r5_in_rst", {bus1.ra_busy, bus1.ra_data}, 33'h0);
    @(negedge clk); idle(); rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); ra_sel = 5'(i); rb_sel = 5'(31 - i);
      #3 if (i == 5 || i == 6) chk("sweep_zero", {bus0.ra_busy, bus0.ra_data}, 33'h0);
    end

    // Write/read and r0
    @(negedge clk); we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF;
    @(negedge clk); idle(); ra_sel = 5'd7;
    #3 chk("r7", {bus0.ra_busy, bus0.ra_data}, {1'b0, 32'hDEADBEEF});
    @(negedge clk); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; ra_sel = 5'd0;
    #3 chk("r0_same", {bus1.ra_busy, bus1.ra_data}, 33'h0);
    @(negedge clk); idle();
    #3 chk("r0_next", {bus0.ra_busy, bus0.ra_data}, 33'h0);

    // Bypass versus registered read
    @(negedge clk); we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5; rb_sel = 5'd3;
    #3 chk("byp_on", {bus1.rb_busy, bus1.rb_data}, {1'b0, 32'hA5A5A5A5});
    chk("byp_off", {bus0.rb_busy, bus0.rb_data}, 33'h0);

    // Link port alone, then link/writeback collision on r31
    @(negedge clk); idle(); link_en = 1'b1; link_data = 32'h100; ra_sel = 5'd31;
    #3 chk("link_byp", {bus1.ra_busy, bus1.ra_data}, {1'b0, 32'h100});
    chk("link_nobyp", {bus0.ra_busy, bus0.ra_data}, 33'h0);
    @(negedge clk); link_en = 1'b1; link_data = 32'h111; we = 1'b1; waddr = 5'd31; wdata = 32'h200;
    #3 chk("coll_byp", {bus1.ra_busy, bus1.ra_data}, {1'b0, 32'h111});
    @(negedge clk); idle();
    #3 chk("coll_r31", {bus0.ra_busy, bus0.ra_data}, {1'b0, 32'h111});

    // Scoreboard
    @(negedge clk); issue_en = 1'b1; issue_rd = 5'd9; ra_sel = 5'd9;
    @(negedge clk); idle();
    #3 chk("busy9_set", {31'h0, bus0.ra_busy}, 33'h1);
    @(negedge clk); issue_en = 1'b1; issue_rd = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h9;
    @(negedge clk); idle();
    #3 chk("busy9_keep", {31'h0, bus1.ra_busy}, 33'h1);
    @(negedge clk); we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    @(negedge clk); idle();
    #3 chk("busy9_clr", {31'h0, bus0.ra_busy}, 33'h0);
    @(negedge clk); issue_en = 1'b1; issue_rd = 5'd0; ra_sel = 5'd0;
    @(negedge clk); idle();
    #3 chk("busy0", {31'h0, bus0.ra_busy}, 33'h0);

    // Flush beats a same-cycle issue
    @(negedge clk); issue_en = 1'b1; issue_rd = 5'd4;
    @(negedge clk); issue_rd = 5'd12;
    @(negedge clk); issue_rd = 5'd31;
    @(negedge clk); idle(); ra_sel = 5'd4; rb_sel = 5'd12;
    #3 chk("busy4_pre", {31'h0, bus0.ra_busy}, 33'h1);
    chk("busy12_pre", {31'h0, bus0.rb_busy}, 33'h1);
    @(negedge clk); flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd4;
    @(negedge clk); idle();
    #3 chk("flush4", {31'h0, bus0.ra_busy}, 33'h0);
    chk("flush12", {31'h0, bus0.rb_busy}, 33'h0);
    @(negedge clk); ra_sel = 5'd31;
    #3 chk("flush31", {31'h0, bus0.ra_busy}, 33'h0);

    // Randomized traffic, selects biased towards colliding addresses
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      we        = $urandom_range(0, 1) == 1;
      waddr     = 5'($urandom_range(0, 31));
      wdata     = $urandom;
      link_en   = ($urandom_range(0, 3) == 0);
      link_data = $urandom;
      issue_en  = $urandom_range(0, 1) == 1;
      issue_rd  = 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 4))
        0: ra_sel = waddr;
        1: ra_sel = 5'd31;
        2: ra_sel = issue_rd;
        3: ra_sel = 5'd0;
        default: ra_sel = 5'($urandom_range(0, 31));
      endcase
      rb_sel = ($urandom_range(0, 1) == 1) ? ra_sel : 5'($urandom_range(0, 31));
    end

    @(negedge clk); idle(); rst = 1'b0;
    @(negedge clk); #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
